// File: rtl/kv_wr_sched_pkg.sv
// rtl/kv_wr_sched_pkg.sv - write-source encodings and request type shared by kv_wr_sched
package kv_wr_sched_pkg;

   localparam logic [1:0] SRC_NONE = 2'b00;
   localparam logic [1:0] SRC_1    = 2'b01;
   localparam logic [1:0] SRC_2    = 2'b10;
   localparam logic [1:0] SRC_BOTH = 2'b11;

   localparam int KV_KEY_WIDTH   = 64;
   localparam int KV_VALUE_WIDTH = 128;

   typedef struct packed {
      logic [KV_KEY_WIDTH-1:0]   key;
      logic [KV_VALUE_WIDTH-1:0] value;
   } kv_req_t;

endpackage

// File: rtl/kv_req_fifo.sv
// rtl/kv_req_fifo.sv - per-requester synchronous FIFO, no bypass; head visible the cycle after push
import kv_wr_sched_pkg::*;

module kv_req_fifo #(
   parameter int DATA_WIDTH = 192,
   parameter int DEPTH      = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  pop_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  head_valid_o,
   output logic [DATA_WIDTH-1:0] head_data_o
);

   localparam int AW = $clog2(DEPTH);

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   logic [AW:0]           wr_ptr_q;
   logic [AW:0]           rd_ptr_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   assign empty_o      = (wr_ptr_q == rd_ptr_q);
   assign full_o       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_valid_o = !empty_o;
   assign head_data_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/kv_wr_sched.sv
// rtl/kv_wr_sched.sv - two-requester round-robin write scheduler for the key/value store port
// Define KV_WR_SCHED_COALESCE_EN to merge equal-key heads into one write (requester 2 value wins).
import kv_wr_sched_pkg::*;

module kv_wr_sched #(
   parameter int KEY_WIDTH   = 64,
   parameter int VALUE_WIDTH = 128,
   parameter int FIFO_DEPTH  = 4,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req1_valid_i,
   output logic                   req1_ready_o,
   input  logic [KEY_WIDTH-1:0]   req1_key_i,
   input  logic [VALUE_WIDTH-1:0] req1_value_i,
   input  logic                   req2_valid_i,
   output logic                   req2_ready_o,
   input  logic [KEY_WIDTH-1:0]   req2_key_i,
   input  logic [VALUE_WIDTH-1:0] req2_value_i,
   output logic                   wr_valid_o,
   input  logic                   wr_ready_i,
   output logic [KEY_WIDTH-1:0]   wr_key_o,
   output logic [VALUE_WIDTH-1:0] wr_value_o,
   output logic [1:0]             wr_src_o,
   output logic [CNT_WIDTH-1:0]   grant1_cnt_o,
   output logic [CNT_WIDTH-1:0]   grant2_cnt_o,
   output logic [CNT_WIDTH-1:0]   coalesce_cnt_o,
   output logic                   busy_o
);

   localparam int DW = KEY_WIDTH + VALUE_WIDTH;

   logic          f1_full, f1_empty, f1_hv;
   logic          f2_full, f2_empty, f2_hv;
   logic [DW-1:0] f1_head, f2_head;
   logic          load, grant1, grant2, coal;
   logic [1:0]    src_d;
   logic          prio_q;   // 0 = requester 1 preferred, 1 = requester 2

   logic [KEY_WIDTH-1:0]   key1, key2;
   logic [VALUE_WIDTH-1:0] val1, val2;

   assign key1 = f1_head[DW-1:VALUE_WIDTH];
   assign val1 = f1_head[VALUE_WIDTH-1:0];
   assign key2 = f2_head[DW-1:VALUE_WIDTH];
   assign val2 = f2_head[VALUE_WIDTH-1:0];

   kv_req_fifo #(.DATA_WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_i       (req1_valid_i),
      .data_i       ({req1_key_i, req1_value_i}),
      .pop_i        (grant1),
      .full_o       (f1_full),
      .empty_o      (f1_empty),
      .head_valid_o (f1_hv),
      .head_data_o  (f1_head)
   );

   kv_req_fifo #(.DATA_WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo2 (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_i       (req2_valid_i),
      .data_i       ({req2_key_i, req2_value_i}),
      .pop_i        (grant2),
      .full_o       (f2_full),
      .empty_o      (f2_empty),
      .head_valid_o (f2_hv),
      .head_data_o  (f2_head)
   );

   assign req1_ready_o = !f1_full;
   assign req2_ready_o = !f2_full;
   assign load         = !wr_valid_o || wr_ready_i;
   assign src_d        = {grant2, grant1};
   assign busy_o       = !f1_empty || !f2_empty || wr_valid_o;

   always_comb begin
      grant1 = 1'b0;
      grant2 = 1'b0;
      coal   = 1'b0;
      if (load) begin
`ifdef KV_WR_SCHED_COALESCE_EN
         coal = f1_hv && f2_hv && (key1 == key2);
`endif
         if (coal) begin
            grant1 = 1'b1;
            grant2 = 1'b1;
         end else if (f1_hv && (!f2_hv || !prio_q)) begin
            grant1 = 1'b1;
         end else if (f2_hv) begin
            grant2 = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_valid_o   <= 1'b0;
         wr_key_o     <= '0;
         wr_value_o   <= '0;
         wr_src_o     <= SRC_NONE;
         prio_q       <= 1'b0;
         grant1_cnt_o <= '0;
         grant2_cnt_o <= '0;
      end else if (load) begin
         wr_valid_o <= grant1 || grant2;
         wr_src_o   <= src_d;
         if (grant1 || grant2) begin
            wr_key_o   <= grant1 ? key1 : key2;
            wr_value_o <= grant2 ? val2 : val1;
         end
         // A single grant hands priority to the other side; a merged grant leaves it alone.
         if (grant1 ^ grant2) prio_q <= grant1;
         if (src_d[0] && grant1_cnt_o != '1) grant1_cnt_o <= grant1_cnt_o + 1'b1;
         if (src_d[1] && grant2_cnt_o != '1) grant2_cnt_o <= grant2_cnt_o + 1'b1;
      end
   end

`ifdef KV_WR_SCHED_COALESCE_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         coalesce_cnt_o <= '0;
      end else if (load && src_d == SRC_BOTH && coalesce_cnt_o != '1) begin
         coalesce_cnt_o <= coalesce_cnt_o + 1'b1;
      end
   end
`else
   assign coalesce_cnt_o = '0;
`endif

endmodule

// File: tb/tb_kv_wr_sched.sv
// tb/tb_kv_wr_sched.sv - randomized scoreboard bench for kv_wr_sched against a queue-based model
module tb_kv_wr_sched;
   import kv_wr_sched_pkg::*;

   localparam int KW    = 64;
   localparam int VW    = 128;
   localparam int DEPTH = 4;
   localparam int CW    = 2;
   localparam int CMAX  = (1 << CW) - 1;
`ifdef KV_WR_SCHED_COALESCE_EN
   localparam bit COAL = 1'b1;
`else
   localparam bit COAL = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          r1v = 1'b0, r2v = 1'b0, wr_rdy = 1'b0;
   logic [KW-1:0] r1k = '0, r2k = '0;
   logic [VW-1:0] r1d = '0, r2d = '0;

   logic          req1_ready_o, req2_ready_o, wr_valid_o, busy_o;
   logic [KW-1:0] wr_key_o;
   logic [VW-1:0] wr_value_o;
   logic [1:0]    wr_src_o;
   logic [CW-1:0] grant1_cnt_o, grant2_cnt_o, coalesce_cnt_o;

   kv_wr_sched #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .req1_valid_i   (r1v),
      .req1_ready_o   (req1_ready_o),
      .req1_key_i     (r1k),
      .req1_value_i   (r1d),
      .req2_valid_i   (r2v),
      .req2_ready_o   (req2_ready_o),
      .req2_key_i     (r2k),
      .req2_value_i   (r2d),
      .wr_valid_o     (wr_valid_o),
      .wr_ready_i     (wr_rdy),
      .wr_key_o       (wr_key_o),
      .wr_value_o     (wr_value_o),
      .wr_src_o       (wr_src_o),
      .grant1_cnt_o   (grant1_cnt_o),
      .grant2_cnt_o   (grant2_cnt_o),
      .coalesce_cnt_o (coalesce_cnt_o),
      .busy_o         (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [KW-1:0] key;
      logic [VW-1:0] value;
      logic [1:0]    src;
   } exp_t;

   kv_req_t mq1[$], mq2[$];
   exp_t    exp_q[$];
   bit      m_valid = 1'b0, m_prio = 1'b0;
   int      g1 = 0, g2 = 0, gc = 0;
   int      n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   // Reference model: queues per requester, one output slot, round-robin priority bit.
   always @(posedge clk) begin
      bit   rdy1, rdy2, h1, h2;
      exp_t e;
      if (!rst_n) begin
         mq1.delete(); mq2.delete(); exp_q.delete();
         m_valid = 1'b0; m_prio = 1'b0; g1 = 0; g2 = 0; gc = 0;
      end else begin
         rdy1 = mq1.size() < DEPTH;
         rdy2 = mq2.size() < DEPTH;
         if (!m_valid || wr_rdy) begin
            h1 = mq1.size() > 0;
            h2 = mq2.size() > 0;
            if (COAL && h1 && h2 && mq1[0].key == mq2[0].key) begin
               e = '{mq1[0].key, mq2[0].value, 2'b11};
               void'(mq1.pop_front()); void'(mq2.pop_front());
               g1++; g2++; gc++;
            end else if (h1 && (!h2 || !m_prio)) begin
               e = '{mq1[0].key, mq1[0].value, 2'b01};
               void'(mq1.pop_front());
               g1++; m_prio = 1'b1;
            end else if (h2) begin
               e = '{mq2[0].key, mq2[0].value, 2'b10};
               void'(mq2.pop_front());
               g2++; m_prio = 1'b0;
            end
            m_valid = h1 || h2;
            if (m_valid) exp_q.push_back(e);
         end
         if (r1v && rdy1) mq1.push_back('{r1k, r1d});
         if (r2v && rdy2) mq2.push_back('{r2k, r2d});
      end
   end

   // Monitor: checks every presented write against the scoreboard head, plus status outputs.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_wr_valid", wr_valid_o, 0);
         chk("rst_wr_key", wr_key_o, 0);
         chk("rst_wr_value", wr_value_o, 0);
         chk("rst_wr_src", wr_src_o, 0);
         chk("rst_grant1_cnt", grant1_cnt_o, 0);
         chk("rst_grant2_cnt", grant2_cnt_o, 0);
         chk("rst_coalesce_cnt", coalesce_cnt_o, 0);
         chk("rst_busy", busy_o, 0);
         chk("rst_req1_ready", req1_ready_o, 1);
         chk("rst_req2_ready", req2_ready_o, 1);
      end else begin
         chk("wr_valid", wr_valid_o, m_valid);
         chk("req1_ready", req1_ready_o, mq1.size() < DEPTH);
         chk("req2_ready", req2_ready_o, mq2.size() < DEPTH);
         chk("busy", busy_o, (mq1.size() > 0) || (mq2.size() > 0) || m_valid);
         chk("grant1_cnt", grant1_cnt_o, sat(g1));
         chk("grant2_cnt", grant2_cnt_o, sat(g2));
         chk("coalesce_cnt", coalesce_cnt_o, sat(gc));
         if (wr_valid_o) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_write act_key=%0h exp=none t=%0t", wr_key_o, $time);
            end else begin
               chk("wr_key", wr_key_o, exp_q[0].key);
               chk("wr_value", wr_value_o, exp_q[0].value);
               chk("wr_src", wr_src_o, exp_q[0].src);
               if (wr_rdy) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic cyc(input bit v1, input logic [KW-1:0] k1, input logic [VW-1:0] d1,
                      input bit v2, input logic [KW-1:0] k2, input logic [VW-1:0] d2,
                      input bit rdy);
      r1v = v1; r1k = k1; r1d = d1;
      r2v = v2; r2k = k2; r2d = d2;
      wr_rdy = rdy;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n, input bit rdy);
      repeat (n) cyc(0, '0, '0, 0, '0, '0, rdy);
   endtask

   initial begin
      int waited;
      idle(3, 1'b1);
      rst_n = 1'b1;
      idle(1, 1'b1);

      cyc(1, 64'h10, 128'h55, 0, '0, '0, 1'b1);
      idle(4, 1'b1);

      for (int i = 0; i < 4; i++)
         cyc(1, 64'h100 + i, 128'h1000 + i, 1, 64'h200 + i, 128'h2000 + i, 1'b1);
      idle(10, 1'b1);

      for (int i = 0; i < 6; i++)
         cyc(1, 64'h300 + i, 128'h900 + i, 0, '0, '0, 1'b0);
      chk("bp_req1_ready_low", req1_ready_o, 0);
      idle(3, 1'b0);
      idle(12, 1'b1);

      cyc(1, 64'h20, 128'hA, 1, 64'h20, 128'hB, 1'b1);
      idle(6, 1'b1);

      for (int i = 0; i < 2; i++)
         cyc(1, 64'h400 + i, 128'h40 + i, 1, 64'h500 + i, 128'h50 + i, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_wr_valid", wr_valid_o, 0);
      chk("async_rst_busy", busy_o, 0);
      idle(2, 1'b1);
      rst_n = 1'b1;
      idle(5, 1'b1);

      repeat (2000)
         cyc($urandom_range(0, 3) != 0, 64'($urandom_range(0, 3)),
             {$urandom, $urandom, $urandom, $urandom},
             $urandom_range(0, 3) != 0, 64'($urandom_range(0, 3)),
             {$urandom, $urandom, $urandom, $urandom},
             $urandom_range(0, 3) != 0);

      waited = 0;
      while ((busy_o || exp_q.size() != 0) && waited < 100) begin
         idle(1, 1'b1);
         waited++;
      end
      chk("drain_busy", busy_o, 0);
      chk("drain_pending", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
